// File: rtl/mdc_ctrl_pkg.sv
// mdc_ctrl_pkg: shared FSM state encoding and default widths for the MDC reconfiguration controller
// Contents: state_t (RUN, DRAIN, SWITCH, SETTLE; 2 bits), DEF_ID_W, DEF_DATA_W. No ports.
package mdc_ctrl_pkg;

    localparam int DEF_ID_W   = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } state_t;

endpackage

// File: rtl/mdc_token_counter.sv
// mdc_token_counter: up/down saturating count of tokens in flight with sticky underflow flag
// Ports: clock, reset (async active-low), inc/dec (count events), clr (force to zero),
//        count (current value), at_zero/at_max (boundary flags), underflow (sticky, reset-only clear).
module mdc_token_counter
    import mdc_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             underflow
);

    assign at_zero = (count == '0);
    assign at_max  = &count;

    // Simultaneous inc and dec cancel; a lone dec at zero holds zero and flags underflow.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            if (at_zero) underflow <= 1'b1;
            else         count     <= count - CNT_W'(1);
        end

endmodule

// File: rtl/mdc_reconfig_ctrl.sv
// mdc_reconfig_ctrl: gates the network input stream and sequences drain/switch/settle on ID change
// Ports: clock, reset (async active-low); cfg_id/cfg_valid/cfg_ready (reconfig request + one-cycle ack);
//        ID (network config ID); s_data/s_wr/s_full (upstream); n_data/n_wr/n_full (network input);
//        o_wr (network output monitor); busy (not in RUN); err_underflow (sticky).
// Build option MDC_RECONF_TIMEOUT_EN: adds a DRAIN timeout of TIMEOUT_CYC cycles and sticky err_timeout.
module mdc_reconfig_ctrl
    import mdc_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ID_W        = DEF_ID_W,
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 2,
    parameter int RESET_ID    = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [ID_W-1:0]   ID,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_wr,
    output logic              s_full,
    output logic [DATA_W-1:0] n_data,
    output logic              n_wr,
    input  logic              n_full,
    input  logic              o_wr,
    output logic              busy,
    output logic              err_underflow
`ifdef MDC_RECONF_TIMEOUT_EN
    ,
    output logic              err_timeout
`endif
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t           state;
    logic [ID_W-1:0]  pend_id;
    logic [SW-1:0]    settle;
    logic [CNT_W-1:0] count;
    logic             at_zero, sat, drained, timeout;

    assign n_data = s_data;
    assign n_wr   = s_wr & (state == RUN) & ~sat;
    assign s_full = n_full | (state != RUN) | sat;
    assign busy   = (state != RUN);
    // The last token leaving this cycle counts as drained, saving a cycle.
    assign drained = at_zero | ((count == CNT_W'(1)) & o_wr);

`ifdef MDC_RECONF_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] timer;
    // timer holds the number of DRAIN cycles already elapsed, so this fires on DRAIN cycle TIMEOUT_CYC.
    assign timeout = (state == DRAIN) && (timer == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            timer <= (state == DRAIN) ? timer + TW'(1) : '0;
            if (timeout) err_timeout <= 1'b1;
        end
`else
    assign timeout = 1'b0;
`endif

    mdc_token_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (n_wr & ~n_full),
        .dec       (o_wr),
        .clr       (timeout),
        .count     (count),
        .at_zero   (at_zero),
        .at_max    (sat),
        .underflow (err_underflow)
    );

    // Requests are ignored while cfg_ready is high so a held cfg_valid is not re-acknowledged.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= RUN;
            ID        <= ID_W'(RESET_ID);
            pend_id   <= '0;
            settle    <= '0;
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b0;
            case (state)
                RUN:
                    if (cfg_valid && !cfg_ready) begin
                        if (cfg_id == ID) begin
                            cfg_ready <= 1'b1;
                        end else begin
                            pend_id <= cfg_id;
                            state   <= DRAIN;
                        end
                    end
                DRAIN:
                    if (drained || timeout) state <= SWITCH;
                SWITCH: begin
                    ID     <= pend_id;
                    settle <= SW'(SETTLE_CYC - 1);
                    state  <= SETTLE;
                end
                default:
                    if (settle == '0) begin
                        state     <= RUN;
                        cfg_ready <= 1'b1;
                    end else begin
                        settle <= settle - SW'(1);
                    end
            endcase
        end

endmodule

// File: tb/tb_mdc_reconfig_ctrl.sv
// tb_mdc_reconfig_ctrl: directed self-checking bench for mdc_reconfig_ctrl (SETTLE_CYC=2, TIMEOUT_CYC=16)
module tb_mdc_reconfig_ctrl;
    import mdc_ctrl_pkg::*;

    logic        clock = 1'b0, reset = 1'b0;
    logic [7:0]  cfg_id = '0, id;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [31:0] s_data = '0, n_data;
    logic        s_wr = 1'b0, s_full, n_wr, n_full = 1'b0, o_wr = 1'b0, busy, err_underflow;
`ifdef MDC_RECONF_TIMEOUT_EN
    logic        err_timeout;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    mdc_reconfig_ctrl #(
        .DATA_W(32), .ID_W(8), .CNT_W(8), .SETTLE_CYC(2), .RESET_ID(0), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset(reset), .cfg_id(cfg_id), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ID(id), .s_data(s_data), .s_wr(s_wr), .s_full(s_full), .n_data(n_data), .n_wr(n_wr),
        .n_full(n_full), .o_wr(o_wr), .busy(busy), .err_underflow(err_underflow)
`ifdef MDC_RECONF_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    typedef struct {
        logic       cv;
        logic [7:0] cid;
        logic       sw, nf, ow;
        logic       e_sfull, e_nwr, e_busy, e_rdy;
        logic [7:0] e_id, e_cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [7:0] cid, input logic sw, input logic nf, input logic ow);
        cfg_valid = cv;
        cfg_id    = cid;
        s_wr      = sw;
        n_full    = nf;
        o_wr      = ow;
        s_data    = $urandom;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int peak, mdl;
        // cycle-by-cycle: inputs, then expected outputs observed in that same cycle
        tbl[0] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1};
        tbl[2] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        tbl[3] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[4] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0};
        tbl[5] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

        do_reset();
        chk("rst_id", id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_underflow", err_underflow, 0);
        chk("rst_sfull", s_full, 0);
        chk("rst_count", dut.count, 0);

        // gating, counting and same-ID no-op request
        for (int i = 0; i < 7; i++) begin
            tick();
            drive(tbl[i].cv, tbl[i].cid, tbl[i].sw, tbl[i].nf, tbl[i].ow);
            chk($sformatf("tbl%0d_sfull", i), s_full, tbl[i].e_sfull);
            chk($sformatf("tbl%0d_nwr", i), n_wr, tbl[i].e_nwr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_id", i), id, tbl[i].e_id);
            chk($sformatf("tbl%0d_count", i), dut.count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ndata", i), n_data, s_data);
        end

        // 20 writes, each echoed at the output 3 cycles later
        peak = 0;
        mdl  = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            drive(0, 0, i < 20, 0, i >= 3 && i < 23);
            chk($sformatf("stream%0d_count", i), dut.count, mdl);
            if (int'(dut.count) > peak) peak = int'(dut.count);
            mdl = mdl + int'(s_wr) - int'(o_wr);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        chk("stream_peak", peak, 3);
        chk("stream_end_count", dut.count, 0);
        chk("stream_underflow", err_underflow, 0);
        chk("stream_id", id, 0);

        // empty network, switch to ID 1: request at k=0
        for (int k = 0; k < 8; k++) begin
            tick();
            drive(k <= 5, 1, 0, 0, 0);
            chk($sformatf("empty%0d_sfull", k), s_full, k >= 1 && k <= 4);
            chk($sformatf("empty%0d_id", k), id, (k >= 3) ? 1 : 0);
            chk($sformatf("empty%0d_ready", k), cfg_ready, k == 5);
            chk($sformatf("empty%0d_busy", k), busy, k >= 1 && k <= 4);
        end

        // 5 tokens in flight, switch to ID 2; cfg_id change during DRAIN must be ignored
        do_reset();
        for (int j = 0; j < 5; j++) begin
            tick();
            drive(0, 0, 1, 0, 0);
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            drive(k <= 13, (k >= 2) ? 8'd7 : 8'd2, k == 1 || k == 2, 0,
                  k == 3 || k == 5 || k == 6 || k == 7 || k == 9);
            chk($sformatf("drain%0d_busy", k), busy, k >= 1 && k <= 12);
            chk($sformatf("drain%0d_id", k), id, (k >= 11) ? 2 : 0);
            chk($sformatf("drain%0d_ready", k), cfg_ready, k == 13);
            if (k == 1) begin
                chk("drain_sfull", s_full, 1);
                chk("drain_nwr_blocked", n_wr, 0);
            end
            if (k == 3) chk("drain_count5", dut.count, 5);
            if (k == 9) chk("drain_state_last", dut.state, DRAIN);
            if (k == 10) chk("drain_state_switch", dut.state, SWITCH);
        end

        // underflow is sticky
        tick();
        drive(0, 0, 0, 0, 1);
        chk("uf_count_before", dut.count, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("uf_count_after", dut.count, 0);
        chk("uf_flag", err_underflow, 1);
        repeat (3) tick();
        chk("uf_flag_held", err_underflow, 1);

        // reset asserted in SETTLE aborts the switch to ID 3
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(1, 3, 0, 0, 0);
        end
        chk("abort_in_settle", dut.state, SETTLE);
        chk("abort_id_before", id, 3);
        reset = 1'b0;
        #1;
        chk("abort_id", id, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", dut.state, RUN);
        chk("abort_uf_clear", err_underflow, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("abort%0d_noack", k), cfg_ready, 0);
            chk($sformatf("abort%0d_busy", k), busy, 0);
        end

`ifdef MDC_RECONF_TIMEOUT_EN
        // one token never returns; timeout forces the switch to ID 4
        do_reset();
        tick();
        drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 21; k++) begin
            tick();
            drive(k <= 20, 4, 0, 0, 0);
            if (k == 16) begin
                chk("to_state_drain", dut.state, DRAIN);
                chk("to_flag_before", err_timeout, 0);
                chk("to_count_before", dut.count, 1);
            end
            if (k == 17) begin
                chk("to_state_switch", dut.state, SWITCH);
                chk("to_flag", err_timeout, 1);
                chk("to_count_cleared", dut.count, 0);
            end
            if (k == 18) chk("to_id", id, 4);
            if (k == 20) chk("to_ready", cfg_ready, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
